// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for MIPS mult/multu/div/divu.
// One shift-add or restoring shift-subtract step per cycle; results land in HI/LO.
`timescale 1ns/1ps

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [1:0]       MDControl,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               is_div_q, neg_a_q, neg_b_q, dbz_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic               busy_q, done_q, div_by_zero_q;

    logic               in_neg_a, in_neg_b, in_dbz;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    // Operand conditioning: signed ops iterate on magnitudes, signs are reapplied in FIX.
    always_comb begin
        in_neg_a = ~MDControl[0] & SrcA[WIDTH-1];
        in_neg_b = ~MDControl[0] & SrcB[WIDTH-1];
        in_mag_a = in_neg_a ? -SrcA : SrcA;
        in_mag_b = in_neg_b ? -SrcB : SrcB;
        in_dbz   = MDControl[1] & (SrcB == '0);
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_d     = acc_q;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift[WIDTH-1:0] - b_q;
        if (is_div_q) begin
            if (div_shift >= {1'b0, b_q})
                acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (dbz_q) begin
            hi_d = a_q;
            lo_d = '1;
        end else if (is_div_q) begin
            lo_d = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: all state, including HI/LO and the working operands, is reset; there is
    // no array storage here that would justify leaving registers unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            is_div_q      <= 1'b0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            dbz_q         <= 1'b0;
            cnt_q         <= '0;
            acc_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        is_div_q      <= MDControl[1];
                        neg_a_q       <= in_neg_a;
                        neg_b_q       <= in_neg_b;
                        dbz_q         <= in_dbz;
                        a_q           <= in_dbz ? SrcA : in_mag_a;
                        b_q           <= in_mag_b;
                        acc_q         <= {{WIDTH{1'b0}}, MDControl[1] ? in_mag_a : in_mag_b};
                        cnt_q         <= '0;
                        busy_q        <= 1'b1;
                        div_by_zero_q <= 1'b0;
                        state_q       <= in_dbz ? FIX : RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    hi_q          <= hi_d;
                    lo_q          <= lo_d;
                    div_by_zero_q <= dbz_q;
                    done_q        <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against
// an arithmetic reference model (64-bit products, native divide/modulo).
`timescale 1ns/1ps

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcA, SrcB;
    logic [1:0]  MDControl;
    logic        start;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_prev = '0;
    logic [31:0] lo_prev = '0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .MDControl(MDControl),
        .start(start), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: HI/LO straight from the architectural arithmetic rules.
    function automatic void model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output bit dbz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (c)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    dbz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
                end else if (c == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit poke_done);
        logic [31:0] ehi, elo;
        bit edbz, seen;
        int lat, edges;
        model(c, a, b, ehi, elo, edbz);
        lat  = edbz ? 2 : 34;
        seen = 1'b0;
        @(negedge clk);
        SrcA = a; SrcB = b; MDControl = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        SrcA = $urandom; SrcB = $urandom; MDControl = 2'($urandom);
        for (edges = 1; edges <= 60; edges++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            check("busy_run", busy, 1);
            check("hi_hold", HI, hi_prev);
            check("lo_hold", LO, lo_prev);
            check("dbz_run", div_by_zero, 0);
            start = disturb && (edges == 5);
            if (start) begin
                SrcA = $urandom; SrcB = $urandom; MDControl = 2'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (seen) check("latency", edges, lat);
        else      check("done_timeout", 0, 1);
        check("busy_done", busy, 1);
        check("hi", HI, ehi);
        check("lo", LO, elo);
        check("dbz", div_by_zero, edbz);
        start = poke_done;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("hi_keep", HI, ehi);
        check("lo_keep", LO, elo);
        hi_prev = ehi;
        lo_prev = elo;
    endtask

    task automatic reset_mid(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                             input int at);
        @(negedge clk);
        SrcA = a; SrcB = b; MDControl = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at - 1) @(negedge clk);
        check("busy_before_rst", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        hi_prev = '0;
        lo_prev = '0;
    endtask

    initial begin
        logic [1:0]  c;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; SrcA = '0; SrcB = '0; MDControl = '0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd199999,    1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
        run_op(2'b11, 32'd199999,    32'd10,        1'b0, 1'b1);
        run_op(2'b11, 32'd1,         32'd0,         1'b0, 1'b0);
        run_op(2'b00, 32'd5,         32'hFFFF_FFF0, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'd0,         1'b0, 1'b1);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1'b0);
        reset_mid(2'b10, 32'd1000, 32'd7, 10);
        run_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 50));
                4: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(c, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
